// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave-port AHB arbiter: round-robin address-phase grant with burst and
// lock hold-off, plus tracking of the data-phase owner for response routing.
module ahb_slave_port_arbiter #(
    parameter int NO_OF_MASTERS = 4,
    parameter int MID_W         = $clog2(NO_OF_MASTERS)
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [NO_OF_MASTERS-1:0] req,
    input  logic [NO_OF_MASTERS-1:0] lock,
    input  logic [NO_OF_MASTERS-1:0] burst_cont,
    input  logic                     hready,
    output logic [NO_OF_MASTERS-1:0] hgrant,
    output logic [MID_W-1:0]         addr_owner,
    output logic                     owner_valid,
    output logic [MID_W-1:0]         data_owner,
    output logic                     data_valid,
    output logic                     grant_switch
);

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        LOCKED
    } state_t;

    // Master count in the same width as the wrap arithmetic below, so the
    // modulo works for non-power-of-two master counts.
    localparam logic [MID_W:0] N_W = (MID_W + 1)'(NO_OF_MASTERS);

    state_t           state;
    logic [MID_W-1:0] rr_ptr;
    logic [MID_W-1:0] rr_winner;
    logic [MID_W-1:0] rr_next;
    logic             rr_found;
    logic             do_grant;
    logic             do_release;
    logic             go_locked;

    // Round-robin pick: the first requester at or after rr_ptr, scanning with
    // wrap-around; scanning downward lets the lowest offset overwrite the rest.
    always_comb begin
        rr_winner = '0;
        rr_found  = 1'b0;
        for (int k = NO_OF_MASTERS - 1; k >= 0; k--) begin
            logic [MID_W:0] idx;
            idx = {1'b0, rr_ptr} + (MID_W + 1)'(k);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (req[idx[MID_W-1:0]]) begin
                rr_winner = idx[MID_W-1:0];
                rr_found  = 1'b1;
            end
        end
    end

    // Pointer to the master after the winner, so a re-granted master drops to lowest priority.
    always_comb begin
        logic [MID_W:0] wp1;
        wp1 = {1'b0, rr_winner} + (MID_W + 1)'(1);
        if (wp1 >= N_W) begin
            rr_next = '0;
        end else begin
            rr_next = wp1[MID_W-1:0];
        end
    end

    // Decide per state whether the owner is held, re-arbitrated or released.
    // A locked owner whose lock has dropped is re-arbitrated even mid-burst.
    always_comb begin
        do_grant   = 1'b0;
        do_release = 1'b0;
        go_locked  = 1'b0;
        case (state)
            IDLE: begin
                do_grant = rr_found;
            end
            GRANTED: begin
                if (!burst_cont[addr_owner]) begin
                    if (lock[addr_owner]) begin
                        go_locked = 1'b1;
                    end else if (rr_found) begin
                        do_grant = 1'b1;
                    end else begin
                        do_release = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (!lock[addr_owner]) begin
                    if (rr_found) begin
                        do_grant = 1'b1;
                    end else begin
                        do_release = 1'b1;
                    end
                end
            end
            default: begin
                do_release = 1'b1;
            end
        endcase
    end

    // Ownership FSM: everything advances only on completed transfers (hready=1),
    // except grant_switch, which is a single-cycle pulse.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state        <= IDLE;
            hgrant       <= '0;
            addr_owner   <= '0;
            owner_valid  <= 1'b0;
            data_owner   <= '0;
            data_valid   <= 1'b0;
            grant_switch <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            grant_switch <= 1'b0;
            if (hready) begin
                data_owner <= addr_owner;
                data_valid <= owner_valid & req[addr_owner];
                if (do_grant) begin
                    hgrant       <= {{(NO_OF_MASTERS - 1){1'b0}}, 1'b1} << rr_winner;
                    addr_owner   <= rr_winner;
                    owner_valid  <= 1'b1;
                    rr_ptr       <= rr_next;
                    state        <= lock[rr_winner] ? LOCKED : GRANTED;
                    grant_switch <= !owner_valid || (rr_winner != addr_owner);
                end else if (do_release) begin
                    hgrant       <= '0;
                    owner_valid  <= 1'b0;
                    state        <= IDLE;
                    grant_switch <= 1'b1;
                end else if (go_locked) begin
                    state <= LOCKED;
                end
            end
        end
    end

    a_grant_onehot : assert property (@(posedge hclk) disable iff (hreset)
        $onehot0(hgrant));

    a_grant_valid : assert property (@(posedge hclk) disable iff (hreset)
        ((hgrant != '0) == owner_valid));

    a_stall_hold : assert property (@(posedge hclk) disable iff (hreset)
        !hready |=> $stable({owner_valid, addr_owner}));

    a_lock_burst_hold : assert property (@(posedge hclk) disable iff (hreset)
        (owner_valid && (lock[addr_owner] || (state == GRANTED && burst_cont[addr_owner])))
        |=> $stable({owner_valid, addr_owner}));

    a_ptr_range : assert property (@(posedge hclk) disable iff (hreset)
        ({1'b0, rr_ptr} < N_W));

endmodule
